can_tx_scheduler: RTL

- Multi-mailbox transmit scheduler in front of the CAN bit stuffer/serializer.
- Holds NUM_MB pending frames, each an 11-bit ID plus 32-bit data.
- Arbitrates them by CAN priority (lowest ID wins) and sequences one frame at a time into the stuffer using its start/done handshake.
- Holds the frame fields stable for the whole frame, enforces an inter-frame gap and reports per-mailbox completion.

---
 rtl/can_tx_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/can_tx_scheduler.sv
// Multi-mailbox CAN transmit scheduler: lowest-ID arbitration, start/done handshake to the stuffer,
// inter-frame gap. Define CAN_TX_TIMEOUT_EN to add the WAIT_DONE watchdog.
module can_tx_scheduler #(
    parameter int unsigned NUM_MB         = 4,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic                      wr_en_i,
    input  logic [$clog2(NUM_MB)-1:0] wr_idx_i,
    input  logic [10:0]               wr_id_i,
    input  logic [31:0]               wr_data_i,
    input  logic [NUM_MB-1:0]         abort_i,
    input  logic                      tx_done_i,
    output logic                      tx_start_o,
    output logic [10:0]               tx_msg_id_o,
    output logic [31:0]               tx_data_o,
    output logic [NUM_MB-1:0]         pending_o,
    output logic [NUM_MB-1:0]         complete_o,
    output logic                      wr_err_o,
    output logic                      busy_o,
    output logic                      timeout_o
);
    localparam int unsigned IdxW = $clog2(NUM_MB);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StArb, StStart, StWait, StGap} state_e;

    state_e            state_q, state_d;
    logic [NUM_MB-1:0] pending_q, pending_d;
    logic [NUM_MB-1:0] complete_q, complete_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [10:0]       tx_id_q, tx_id_d;
    logic [31:0]       tx_data_q, tx_data_d;
    logic              wr_err_q, wr_err_d;
    logic [10:0]       mb_id_q   [NUM_MB];
    logic [31:0]       mb_data_q [NUM_MB];

    logic              in_flight, idx_ok, wr_ok, done_evt, timeout_evt;
    logic [NUM_MB-1:0] eligible;
    logic              best_vld;
    logic [IdxW-1:0]   best_idx;
    logic [10:0]       best_id;

    assign in_flight = (state_q == StStart) || (state_q == StWait);
    assign idx_ok    = {1'b0, wr_idx_i} < (IdxW + 1)'(NUM_MB);
    assign wr_ok     = wr_en_i && idx_ok && !(in_flight && (wr_idx_i == win_q));
    assign wr_err_d  = wr_en_i && !wr_ok;
    assign done_evt  = (state_q == StWait) && tx_done_i;

    // Aborts raised in the arbitration cycle already remove their mailbox from contention.
    always_comb begin
        eligible = pending_q & ~abort_i;
        best_vld = 1'b0;
        best_idx = '0;
        best_id  = '0;
        for (int unsigned k = 0; k < NUM_MB; k++) begin
            if (eligible[k] && (!best_vld || (mb_id_q[k] < best_id))) begin
                best_vld = 1'b1;
                best_idx = IdxW'(k);
                best_id  = mb_id_q[k];
            end
        end
    end

`ifdef CAN_TX_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    assign wd_d        = (state_q == StWait) ? wd_q + 16'd1 : 16'd0;
    assign timeout_evt = (state_q == StWait) && !tx_done_i && (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) wd_q <= '0;
        else           wd_q <= wd_d;
    end
`else
    assign timeout_evt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        gap_d      = gap_q;
        tx_id_d    = tx_id_q;
        tx_data_d  = tx_data_q;
        pending_d  = pending_q;
        complete_d = '0;
        unique case (state_q)
            StIdle: if (|pending_q) state_d = StArb;
            StArb: begin
                if (!best_vld) begin
                    state_d = StIdle;
                end else begin
                    state_d = StStart;
                    win_d   = best_idx;
                    // A same-cycle write to the winner goes out with the new contents.
                    if (wr_ok && (wr_idx_i == best_idx)) begin
                        tx_id_d   = wr_id_i;
                        tx_data_d = wr_data_i;
                    end else begin
                        tx_id_d   = best_id;
                        tx_data_d = mb_data_q[best_idx];
                    end
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (done_evt) begin
                    complete_d[win_q] = 1'b1;
                    pending_d[win_q]  = 1'b0;
                    gap_d             = GapW'(GAP_CYCLES - 1);
                    state_d           = StGap;
                end else if (timeout_evt) begin
                    gap_d   = GapW'(GAP_CYCLES - 1);
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == '0) state_d = StIdle;
                else             gap_d = gap_q - GapW'(1);
            end
            default: state_d = StIdle;
        endcase
        for (int unsigned k = 0; k < NUM_MB; k++) begin
            if (abort_i[k] && !(in_flight && (win_q == IdxW'(k)))) pending_d[k] = 1'b0;
        end
        if (wr_ok) pending_d[wr_idx_i] = 1'b1;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            complete_q <= '0;
            win_q      <= '0;
            gap_q      <= '0;
            tx_id_q    <= '0;
            tx_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            complete_q <= complete_d;
            win_q      <= win_d;
            gap_q      <= gap_d;
            tx_id_q    <= tx_id_d;
            tx_data_q  <= tx_data_d;
            wr_err_q   <= wr_err_d;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned k = 0; k < NUM_MB; k++) begin
                mb_id_q[k]   <= '0;
                mb_data_q[k] <= '0;
            end
        end else if (wr_ok) begin
            mb_id_q[wr_idx_i]   <= wr_id_i;
            mb_data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign tx_start_o  = (state_q == StStart);
    assign busy_o      = (state_q != StIdle);
    assign tx_msg_id_o = tx_id_q;
    assign tx_data_o   = tx_data_q;
    assign pending_o   = pending_q;
    assign complete_o  = complete_q;
    assign wr_err_o    = wr_err_q;
    assign timeout_o   = timeout_evt;
endmodule
